// File: rtl/uart_cmd_rx_if.sv
// Serial line and result signals between the board RX pin side and the
// command receiver; the receiver uses the slave modport.
interface uart_cmd_rx_if;
    logic       i_uart;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frameErr;
    logic       o_busy;
    logic [2:0] o_dieSelect;
    logic       o_cmdValid;
    logic       o_badCmd;

    modport slave (
        input  i_uart,
        output o_data, o_valid, o_frameErr, o_busy,
        output o_dieSelect, o_cmdValid, o_badCmd
    );

    modport master (
        output i_uart,
        input  o_data, o_valid, o_frameErr, o_busy,
        input  o_dieSelect, o_cmdValid, o_badCmd
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that also decodes each good byte into the 3-bit
// die-select code used by the die-roll interface.
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    uart_cmd_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

    // Bit 3 flags a defined command; bits 2:0 carry the die-select code.
    function automatic logic [3:0] decode_cmd(input logic [7:0] b);
        logic [3:0] r;
        case (b)
            8'h61:   r = 4'b1_000;
            8'h62:   r = 4'b1_001;
            8'h63:   r = 4'b1_010;
            8'h64:   r = 4'b1_011;
            8'h65:   r = 4'b1_100;
            8'h66:   r = 4'b1_101;
            8'h74:   r = 4'b1_111;
            default: r = 4'b0_000;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
    logic [2:0]       die_q, die_d;
    logic             cmdv_q, cmdv_d;
    logic             bad_q, bad_d;
    logic [3:0]       decode_s;

    // Synchronizer and edge-history flops; all reset high to match an idle line.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= bus.i_uart;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receiver state and output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            die_q   <= 3'b000;
            cmdv_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
            die_q   <= die_d;
            cmdv_q  <= cmdv_d;
            bad_q   <= bad_d;
        end
    end

    // Next-state, bit sampling and command decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        die_d    = die_q;
        cmdv_d   = 1'b0;
        bad_d    = 1'b0;
        decode_s = decode_cmd(shift_q);

        case (state_q)
            ST_IDLE: begin
                // Only a high-to-low transition arms; a held-low break does not.
                if (prev_q && !sync2_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!sync2_q) begin
                        state_d = ST_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = sync2_q;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                // Leaving at mid stop bit keeps back-to-back start edges visible.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (sync2_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        if (decode_s[3]) begin
                            die_d  = decode_s[2:0];
                            cmdv_d = 1'b1;
                        end else begin
                            bad_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_frameErr  = ferr_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_dieSelect = die_q;
    assign bus.o_cmdValid  = cmdv_q;
    assign bus.o_badCmd    = bad_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at 16 clocks per bit.
module tb_uart_cmd_rx;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    int valid_cnt = 0;
    int cmd_cnt   = 0;
    int bad_cnt   = 0;
    int ferr_cnt  = 0;
    int overlap   = 0;
    logic [2:0] die_log[$];

    uart_cmd_rx_if bus();

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Pulse counters and exclusivity watch, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.o_valid)    valid_cnt <= valid_cnt + 1;
        if (bus.o_frameErr) ferr_cnt  <= ferr_cnt + 1;
        if (bus.o_badCmd)   bad_cnt   <= bad_cnt + 1;
        if (bus.o_cmdValid) begin
            cmd_cnt <= cmd_cnt + 1;
            die_log.push_back(bus.o_dieSelect);
        end
        if ((bus.o_valid && bus.o_frameErr) || (bus.o_cmdValid && bus.o_badCmd) ||
            ((bus.o_cmdValid || bus.o_badCmd) && !bus.o_valid))
            overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bus.i_uart = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.i_uart = b[i];
            wait_cycles(CPB);
        end
        bus.i_uart = stop_bit;
        wait_cycles(CPB);
    endtask

    initial begin
        bus.i_uart = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(100);
        check("rst_data", 32'(bus.o_data), 32'h00);
        check("rst_die", 32'(bus.o_dieSelect), 32'h0);
        check("rst_busy", 32'(bus.o_busy), 32'h0);
        check("rst_pulses", 32'(valid_cnt + cmd_cnt + bad_cnt + ferr_cnt), 32'h0);

        // 'c'
        send_frame(8'h63, 1'b1);
        wait_cycles(4);
        check("c_valid_cnt", 32'(valid_cnt), 32'd1);
        check("c_data", 32'(bus.o_data), 32'h63);
        check("c_die", 32'(bus.o_dieSelect), 32'h2);
        check("c_cmd_cnt", 32'(cmd_cnt), 32'd1);
        check("c_bad_cnt", 32'(bad_cnt), 32'd0);

        // 't' then 'f' back to back
        send_frame(8'h74, 1'b1);
        send_frame(8'h66, 1'b1);
        wait_cycles(4);
        check("tf_valid_cnt", 32'(valid_cnt), 32'd3);
        check("tf_cmd_cnt", 32'(cmd_cnt), 32'd3);
        check("tf_die_first", 32'(die_log[1]), 32'h7);
        check("tf_die_second", 32'(die_log[2]), 32'h5);
        check("tf_data", 32'(bus.o_data), 32'h66);

        // 'A' undefined command
        send_frame(8'h41, 1'b1);
        wait_cycles(4);
        check("A_valid_cnt", 32'(valid_cnt), 32'd4);
        check("A_data", 32'(bus.o_data), 32'h41);
        check("A_bad_cnt", 32'(bad_cnt), 32'd1);
        check("A_cmd_cnt", 32'(cmd_cnt), 32'd3);
        check("A_die_hold", 32'(bus.o_dieSelect), 32'h5);

        // 'b' with low stop bit, then line held low (break)
        send_frame(8'h62, 1'b0);
        wait_cycles(5 * CPB);
        check("fe_ferr_cnt", 32'(ferr_cnt), 32'd1);
        check("fe_valid_cnt", 32'(valid_cnt), 32'd4);
        check("fe_data_hold", 32'(bus.o_data), 32'h41);
        check("fe_die_hold", 32'(bus.o_dieSelect), 32'h5);
        check("brk_busy", 32'(bus.o_busy), 32'h0);
        bus.i_uart = 1'b1;
        wait_cycles(20);
        send_frame(8'h61, 1'b1);
        wait_cycles(4);
        check("a_valid_cnt", 32'(valid_cnt), 32'd5);
        check("a_die", 32'(bus.o_dieSelect), 32'h0);
        check("a_data", 32'(bus.o_data), 32'h61);

        // 3-cycle glitch on idle line
        bus.i_uart = 1'b0;
        wait_cycles(3);
        bus.i_uart = 1'b1;
        wait_cycles(2);
        check("gl_busy_mid", 32'(bus.o_busy), 32'h1);
        wait_cycles(20);
        check("gl_busy_end", 32'(bus.o_busy), 32'h0);
        check("gl_no_pulse", 32'(valid_cnt + ferr_cnt), 32'd6);

        // Reset during data bit 4
        bus.i_uart = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.i_uart = i[0];
            wait_cycles(CPB);
        end
        bus.i_uart = 1'b0;
        wait_cycles(CPB / 2);
        rst = 1'b1;
        #1;
        check("mr_data", 32'(bus.o_data), 32'h00);
        check("mr_die", 32'(bus.o_dieSelect), 32'h0);
        check("mr_busy", 32'(bus.o_busy), 32'h0);
        bus.i_uart = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(40);
        check("mr_no_pulse", 32'(valid_cnt + ferr_cnt), 32'd6);
        check("mr_idle", 32'(bus.o_busy), 32'h0);
        send_frame(8'h64, 1'b1);
        wait_cycles(4);
        check("d_valid_cnt", 32'(valid_cnt), 32'd6);
        check("d_die", 32'(bus.o_dieSelect), 32'h3);
        check("d_data", 32'(bus.o_data), 32'h64);
        check("d_cmd_cnt", 32'(cmd_cnt), 32'd5);

        check("overlap", 32'(overlap), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- UART receiver for the dice roller's user command link.
- Deserializes 8N1 frames arriving on the serial input and presents each received byte.
- Decodes the byte into the 3-bit die-select code consumed by the die-roll interface: 000=d4, 001=d6, 010=d8, 011=d10, 100=d12, 101=d20, 111=test mode.
- Sits between the board RX pin and the interface block's user-input port.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 4 to 65535.
- CNT_W, 16, width of the bit-period counter; must hold CLKS_PER_BIT-1.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_reset  input  1  reset, asynchronous, active-high.
- i_uart  input  1  raw serial line, idle high, asynchronous to i_clk.
- o_data  output  8  last correctly framed byte.
- o_valid  output  1  one-cycle pulse when o_data updates.
- o_frameErr  output  1  one-cycle pulse when the stop bit samples low.
- o_busy  output  1  high in any state other than IDLE.
- o_dieSelect  output  3  last valid decoded command.
- o_cmdValid  output  1  one-cycle pulse when o_dieSelect updates.
- o_badCmd  output  1  one-cycle pulse when a good frame holds an undefined byte.

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, shift register=0, both synchronizer flops=1. o_data=8'h00, o_dieSelect=3'b000, all pulse outputs=0, o_busy=0.
- Input path: 2-flop synchronizer on i_uart, plus a third flop holding the previous synced value for edge detection.
- IDLE:
  - A falling edge (prev=1, cur=0) enters START and clears the counter.
  - A line that is continuously low never triggers, so a break does not re-arm until the line returns high.
- START:
  - Count to (CLKS_PER_BIT-1)/2 (integer division), then sample.
  - Sample low: go to DATA, counter=0, bit index=0.
  - Sample high (glitch): return to IDLE with no pulse.
- DATA:
  - Sample every CLKS_PER_BIT cycles, i.e. at mid-bit.
  - Shift LSB first into bit[index].
  - After index 7 is sampled, go to STOP.
- STOP:
  - Sample after CLKS_PER_BIT cycles.
  - Sample high: o_data <= shift register, o_valid=1 for exactly one cycle, then command decode (below).
  - Sample low: o_frameErr=1 for one cycle; o_data, o_dieSelect and all command outputs unchanged.
  - Either way, return to IDLE on the next cycle.
- Command decode: registered in the same cycle as o_valid, so o_cmdValid and o_badCmd are coincident with o_valid.
  - 'a' (8'h61) -> 000
  - 'b' (8'h62) -> 001
  - 'c' (8'h63) -> 010
  - 'd' (8'h64) -> 011
  - 'e' (8'h65) -> 100
  - 'f' (8'h66) -> 101
  - 't' (8'h74) -> 111
  - Any other byte: o_badCmd pulse; o_dieSelect holds its value.
- Latency: o_valid rises 2 sync cycles plus about 9.5 bit periods after the start-bit falling edge on i_uart.
- Back-to-back frames: the return to IDLE happens mid stop bit, so the next start edge is caught with no lost frame.
- Reset asserted mid-frame: immediate return to reset values. A partial frame never produces a pulse. After release, the block waits for a fresh falling edge.
- Pulses never overlap:
  - o_valid and o_frameErr are mutually exclusive.
  - o_cmdValid and o_badCmd are mutually exclusive and only occur with o_valid.

Test Plan (CLKS_PER_BIT=16 in the bench):
- Reset release, line idle high for 100 cycles -> all outputs at reset values, o_busy=0, no pulses.
- Send frame 8'h63 ('c') -> one o_valid pulse with o_data=8'h63; o_cmdValid pulse with o_dieSelect=3'b010; o_badCmd=0.
- Send 't' then 'f' back-to-back, stop bit exactly one bit period -> two o_valid pulses; o_dieSelect goes 111 then 101; two o_cmdValid pulses.
- Send 8'h41 ('A') -> o_valid pulse with o_data=8'h41; o_badCmd pulse; o_dieSelect unchanged from the previous value.
- Send 8'h62 with the stop bit driven low -> o_frameErr pulse; no o_valid; o_data unchanged. Hold the line low for 5 bit times -> no new frame starts. Release high, then send 8'h61 -> o_dieSelect=000.
- Two further cases:
  - 3-cycle low glitch on an idle line -> return to IDLE, no pulses.
  - Assert i_reset during DATA bit 4 -> outputs return to reset values immediately; the following full frame 8'h64 gives o_dieSelect=011.
